// File: rtl/axis_arb_pkg.sv
// Shared constants for the 8-bit AXI-Stream round-robin arbiter:
// FSM encoding, length-limit default and counter widths.
package axis_arb_pkg;

   localparam int unsigned MAX_LEN_DEFAULT = 1500;
   localparam int unsigned BYTE_CNT_W      = 16;
   localparam int unsigned PKT_CNT_W       = 16;

   typedef logic [1:0]            state_t;
   typedef logic [BYTE_CNT_W-1:0] byte_cnt_t;
   typedef logic [PKT_CNT_W-1:0]  pkt_cnt_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_XFER  = 2'd1;
   localparam state_t ST_DRAIN = 2'd2;

   // Increment an index with wrap at n (round-robin pointer advance).
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/axis_8bit_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or after ptr_i,
// wrapping modulo N_SRC.
module rr_pick
   import axis_arb_pkg::*;
#(
   parameter int unsigned N_SRC = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N_SRC-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             found_o
);

   int unsigned cand;

   // NOTE: every output gets a default before the loop so no path can infer a latch.
   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      cand    = 0;
      for (int unsigned k = 0; k < N_SRC; k++) begin
         cand = (32'(ptr_i) + k) % N_SRC;
         if (!found_o && req_i[IDX_W'(cand)]) begin
            idx_o   = IDX_W'(cand);
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axis_8bit_arbiter.sv
// N-source 8-bit AXI-Stream packet arbiter with round-robin grant,
// per-packet length limit (truncate then drain) and packet counter.
module axis_8bit_arbiter
   import axis_arb_pkg::*;
#(
   parameter int unsigned N_SRC   = 4,
   parameter int unsigned MAX_LEN = MAX_LEN_DEFAULT
) (
   input  logic                     clk_8,
   input  logic                     reset_8_n,
   input  logic [N_SRC*8-1:0]       s_axis_tdata_in,
   input  logic [N_SRC-1:0]         s_axis_tvalid_in,
   input  logic [N_SRC-1:0]         s_axis_tlast_in,
   output logic [N_SRC-1:0]         s_axis_tready_out,
   output logic [7:0]               m_axis_tdata_out,
   output logic                     m_axis_tvalid_out,
   output logic                     m_axis_tlast_out,
   input  logic                     m_axis_tready_in,
   output logic [$clog2(N_SRC)-1:0] grant_id_out,
   output logic                     busy_out,
   output logic                     trunc_err_out,
   output logic [15:0]              pkt_cnt_out
);

   localparam int unsigned IDX_W = $clog2(N_SRC);
   localparam byte_cnt_t   LAST_IDX = BYTE_CNT_W'(MAX_LEN - 1);

   state_t           state_q,    state_d;
   logic [IDX_W-1:0] grant_q,    grant_d;
   logic [IDX_W-1:0] rr_ptr_q,   rr_ptr_d;
   byte_cnt_t        byte_cnt_q, byte_cnt_d;
   pkt_cnt_t         pkt_cnt_q,  pkt_cnt_d;
   logic             trunc_q,    trunc_d;

   logic [IDX_W-1:0] pick_idx;
   logic             pick_found;

   logic       sel_valid;
   logic       sel_last;
   logic [7:0] sel_data;
   logic       at_limit;
   logic       xfer_beat;
   logic       drain_beat;
   logic       master_last_beat;

   rr_pick #(
      .N_SRC (N_SRC),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req_i   (s_axis_tvalid_in),
      .ptr_i   (rr_ptr_q),
      .idx_o   (pick_idx),
      .found_o (pick_found)
   );

   assign sel_valid  = s_axis_tvalid_in[grant_q];
   assign sel_last   = s_axis_tlast_in[grant_q];
   assign sel_data   = s_axis_tdata_in[{grant_q, 3'b000} +: 8];
   assign at_limit   = (byte_cnt_q == LAST_IDX);
   assign xfer_beat  = (state_q == ST_XFER)  && sel_valid && m_axis_tready_in;
   assign drain_beat = (state_q == ST_DRAIN) && sel_valid;

   // Master side is a pure pass-through of the granted source; no buffering.
   always_comb begin
      m_axis_tdata_out  = sel_data;
      m_axis_tvalid_out = 1'b0;
      m_axis_tlast_out  = 1'b0;
      s_axis_tready_out = '0;
      case (state_q)
         ST_XFER: begin
            m_axis_tvalid_out          = sel_valid;
            m_axis_tlast_out           = sel_valid && (sel_last || at_limit);
            s_axis_tready_out[grant_q] = m_axis_tready_in;
         end
         ST_DRAIN: begin
            s_axis_tready_out[grant_q] = 1'b1;
         end
         default: ;
      endcase
   end

   assign master_last_beat = m_axis_tvalid_out && m_axis_tready_in && m_axis_tlast_out;

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      byte_cnt_d = byte_cnt_q;
      pkt_cnt_d  = pkt_cnt_q;
      trunc_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               grant_d    = pick_idx;
               byte_cnt_d = '0;
               state_d    = ST_XFER;
            end
         end
         ST_XFER: begin
            if (xfer_beat) begin
               byte_cnt_d = byte_cnt_q + 1'b1;
               // A genuine tlast on the limit beat wins over truncation.
               if (sel_last) begin
                  rr_ptr_d = IDX_W'(wrap_inc(32'(grant_q), N_SRC));
                  state_d  = ST_IDLE;
               end else if (at_limit) begin
                  trunc_d  = 1'b1;
                  rr_ptr_d = IDX_W'(wrap_inc(32'(grant_q), N_SRC));
                  state_d  = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (drain_beat && sel_last) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (master_last_beat) begin
         pkt_cnt_d = pkt_cnt_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_8 or negedge reset_8_n) begin
      if (!reset_8_n) begin
         state_q    <= ST_IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         byte_cnt_q <= '0;
         pkt_cnt_q  <= '0;
         trunc_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         byte_cnt_q <= byte_cnt_d;
         pkt_cnt_q  <= pkt_cnt_d;
         trunc_q    <= trunc_d;
      end
   end

   assign grant_id_out  = grant_q;
   assign busy_out      = (state_q == ST_XFER) || (state_q == ST_DRAIN);
   assign trunc_err_out = trunc_q;
   assign pkt_cnt_out   = pkt_cnt_q;

endmodule

// File: doc/axis_8bit_arbiter.md
AXIS_8BIT_ARBITER -- requirements
Module: axis_8bit_arbiter

Interface
REQ-001 The block SHALL have parameter N_SRC, default 4, giving the number of 8-bit AXI-Stream requesters (2..8).
REQ-002 The block SHALL have parameter MAX_LEN, default 1500, giving the maximum bytes forwarded per packet (2..65535).
REQ-003 The block SHALL have port clk_8, input, 1 bit: the single clock; all logic is in this domain.
REQ-004 The block SHALL have port reset_8_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port s_axis_tdata_in, input, N_SRC*8 bits: requester data, source i in bits [8i+7:8i].
REQ-006 The block SHALL have port s_axis_tvalid_in, input, N_SRC bits: per-requester valid.
REQ-007 The block SHALL have port s_axis_tlast_in, input, N_SRC bits: per-requester end of packet.
REQ-008 The block SHALL have port s_axis_tready_out, output, N_SRC bits: per-requester ready.
REQ-009 The block SHALL have ports m_axis_tdata_out (output, 8), m_axis_tvalid_out (output, 1), m_axis_tlast_out (output, 1) and m_axis_tready_in (input, 1): the single stream to the 8-to-32 width converter.
REQ-010 The block SHALL have port grant_id_out, output, clog2(N_SRC) bits: index of the granted source.
REQ-011 The block SHALL have port busy_out, output, 1 bit: high in the XFER or DRAIN state.
REQ-012 The block SHALL have port trunc_err_out, output, 1 bit: a one-cycle pulse on packet truncation.
REQ-013 The block SHALL have port pkt_cnt_out, output, 16 bits: count of packets completed on the master side.

Function
REQ-014 The block SHALL implement a state machine with states IDLE, XFER and DRAIN, and SHALL exit reset in IDLE.
REQ-015 A beat SHALL occur on a cycle where the selected tvalid and tready are both high; no other cycle SHALL count as a beat.
REQ-016 In IDLE:
- all s_axis_tready_out and m_axis_tvalid_out SHALL be 0;
- if any s_axis_tvalid_in is high, the block SHALL register the grant as the first requesting index at or after rr_ptr (wrapping modulo N_SRC) and move to XFER on the next edge.
REQ-017 Arbitration latency SHALL be one cycle: the first byte of the granted packet can be forwarded in the cycle after the request is seen in IDLE.
REQ-018 In XFER, the master outputs SHALL be combinational pass-through of the granted source:
- m_axis_tdata_out and m_axis_tvalid_out follow the granted source;
- s_axis_tready_out[grant] equals m_axis_tready_in;
- s_axis_tready_out of every other source is 0.
REQ-019 In XFER, a 16-bit byte_cnt SHALL be cleared on entry and incremented on every beat.
REQ-020 m_axis_tlast_out SHALL be the granted source's tlast OR (byte_cnt == MAX_LEN-1), and SHALL be gated by m_axis_tvalid_out.
REQ-021 On an XFER beat with the source's tlast high, the block SHALL go to IDLE and set rr_ptr to grant+1 modulo N_SRC.
REQ-022 On an XFER beat with byte_cnt == MAX_LEN-1 and the source's tlast low, the block SHALL:
- pulse trunc_err_out for one cycle;
- set rr_ptr to grant+1;
- go to DRAIN.
REQ-023 If the source's tlast and the length limit coincide on the same beat, the block SHALL treat it as a normal end of packet: no trunc_err_out, next state IDLE.
REQ-024 In DRAIN:
- m_axis_tvalid_out SHALL be 0;
- s_axis_tready_out[grant] SHALL be 1 and all others 0;
- source bytes SHALL be discarded until a beat with the source's tlast high, then the state SHALL go to IDLE.
REQ-025 pkt_cnt_out SHALL increment by 1 on every master-side tlast beat, wrapping from 0xFFFF to 0.
REQ-026 busy_out SHALL be high exactly in XFER and DRAIN.
REQ-027 grant_id_out SHALL hold the last granted index while in IDLE.
REQ-028 A deasserted m_axis_tready_in SHALL stall XFER indefinitely without changing grant, byte_cnt or state.
REQ-029 A source deasserting tvalid mid-packet SHALL NOT release the grant.

Reset
REQ-030 While reset_8_n is low, asynchronously:
- state = IDLE, rr_ptr = 0, grant = 0, byte_cnt = 0;
- pkt_cnt_out = 0, trunc_err_out = 0, busy_out = 0;
- m_axis_tvalid_out = 0, m_axis_tlast_out = 0, all s_axis_tready_out = 0.
REQ-031 Reset asserted mid-packet SHALL abandon the packet with no tlast emitted, and SHALL NOT produce a trunc_err_out pulse.
REQ-032 Deassertion of reset_8_n SHALL be used synchronised to clk_8 by the instantiating level; the block itself SHALL require no synchroniser.

Structure
REQ-033 State encoding, the MAX_LEN default and the byte_cnt width SHALL reside in a shared package, axis_arb_pkg.
REQ-034 The round-robin next-grant search SHALL be one combinational sub-module, rr_pick, taking the request vector and rr_ptr and returning the index plus a found flag.
REQ-035 The block SHALL contain no FIFO; buffering is left to the downstream width converter.

Verification
REQ-036 Single source: source 2 sends a 5-byte packet, m_axis_tready_in=1 -> 5 bytes out in order, tlast on byte 5, grant_id_out=2, pkt_cnt_out=1, and rr_ptr=3.
REQ-037 Fairness: sources 0..3 continuously request 3-byte packets -> output packet order 0,1,2,3,0, with one IDLE cycle between packets.
REQ-038 Truncation: MAX_LEN=4 and a 7-byte packet on source 1 -> 4 bytes out with tlast on byte 4, one trunc_err_out pulse, the remaining 3 bytes accepted and dropped, busy_out low after the source's tlast.
REQ-039 Coincidence: MAX_LEN=4 and a 4-byte packet -> tlast on byte 4, trunc_err_out stays 0, next state IDLE.
REQ-040 Backpressure: m_axis_tready_in low for 10 cycles mid-packet -> no beats, byte_cnt held, s_axis_tready_out[grant]=0, then resumes with no data loss.
REQ-041 Reset mid-packet: reset_8_n pulsed low after byte 2 of 6 -> all outputs and counters are 0 immediately, and a new request after release is granted starting from source 0.
